// File: rtl/uart_tx_state_machine.sv
// UART transmit framer: serialises one handshaked word as a start bit, 5..MAX_DATA_BITS
// data bits (LSB first), optional parity and one or two stop bits, paced by baud_tick.
module uart_tx_state_machine #(
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_tick,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               parity_mode,
    input  logic                     stop_bits,
    output logic                     tx,
    output logic                     frame_active,
    output logic [3:0]               bit_count,
    output logic                     is_start_bit,
    output logic                     is_data_bit,
    output logic                     is_parity_bit,
    output logic                     is_stop_bit,
    output logic                     tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP_1,
        STOP_2
    } state_t;

    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

    state_t                   state;
    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [3:0]               cfg_bits;
    logic [1:0]               cfg_parity;
    logic                     cfg_two_stop;
    logic                     parity_acc;
    logic [3:0]               clamped_bits;
    logic                     next_acc;
    logic                     last_data;
    logic                     parity_bit;

    always_comb begin
        clamped_bits = data_bits;
        if (data_bits < MIN_BITS) begin
            clamped_bits = MIN_BITS;
        end else if (data_bits > MAX_BITS) begin
            clamped_bits = MAX_BITS;
        end
    end

    // Parity has to include the bit leaving on this tick, so it is built from next_acc.
    assign next_acc  = parity_acc ^ shift_reg[0];
    assign last_data = (bit_count + 4'd1) == cfg_bits;

    always_comb begin
        case (cfg_parity)
            2'd1:    parity_bit = ~next_acc;
            2'd2:    parity_bit = next_acc;
            default: parity_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_done      <= 1'b0;
            bit_count    <= 4'd0;
            parity_acc   <= 1'b0;
            shift_reg    <= '0;
            cfg_bits     <= MIN_BITS;
            cfg_parity   <= 2'd0;
            cfg_two_stop <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx         <= 1'b1;
                    bit_count  <= 4'd0;
                    parity_acc <= 1'b0;
                    if (tx_valid) begin
                        shift_reg    <= tx_data;
                        cfg_bits     <= clamped_bits;
                        cfg_parity   <= parity_mode;
                        cfg_two_stop <= stop_bits;
                        state        <= ARMED;
                    end
                end
                // Waiting here aligns the start bit to a full tick period.
                ARMED: begin
                    if (baud_tick) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_reg  <= shift_reg >> 1;
                        bit_count  <= bit_count + 4'd1;
                        parity_acc <= next_acc;
                        if (last_data) begin
                            if (cfg_parity != 2'd0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP_1;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state <= STOP_1;
                        tx    <= 1'b1;
                    end
                end
                STOP_1: begin
                    if (baud_tick) begin
                        if (cfg_two_stop) begin
                            state <= STOP_2;
                        end else begin
                            state      <= IDLE;
                            tx_done    <= 1'b1;
                            bit_count  <= 4'd0;
                            parity_acc <= 1'b0;
                        end
                    end
                end
                STOP_2: begin
                    if (baud_tick) begin
                        state      <= IDLE;
                        tx_done    <= 1'b1;
                        bit_count  <= 4'd0;
                        parity_acc <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready      = (state == IDLE);
    assign frame_active  = (state == START) || (state == DATA) || (state == PARITY) ||
                           (state == STOP_1) || (state == STOP_2);
    assign is_start_bit  = (state == START);
    assign is_data_bit   = (state == DATA);
    assign is_parity_bit = (state == PARITY);
    assign is_stop_bit   = (state == STOP_1) || (state == STOP_2);

endmodule

// File: tb/tb_uart_tx_state_machine.sv
// Self-checking bench for uart_tx_state_machine: expected frames are queued at each
// handshake and a line monitor compares every bit, indicator and the done pulse.
module tb_uart_tx_state_machine;

    typedef struct {
        logic [12:0] bits;
        int          len;
        int          nbits;
        bit          has_par;
    } frame_t;

    typedef struct {
        logic [8:0] data;
        logic [3:0] dbits;
        logic [1:0] pmode;
        logic       sbits;
        int         exp_nbits;
        logic       exp_par;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       tx_valid;
    logic [8:0] tx_data;
    logic       tx_ready;
    logic [3:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       tx;
    logic       frame_active;
    logic [3:0] bit_count;
    logic       is_start_bit;
    logic       is_data_bit;
    logic       is_parity_bit;
    logic       is_stop_bit;
    logic       tx_done;

    int     total = 0;
    int     bad = 0;
    int     frames_done = 0;
    int     done_pulses = 0;
    int     exp_done = 0;
    frame_t exp_q[$];
    vec_t   vecs[8];

    uart_tx_state_machine #(.MAX_DATA_BITS(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .tx           (tx),
        .frame_active (frame_active),
        .bit_count    (bit_count),
        .is_start_bit (is_start_bit),
        .is_data_bit  (is_data_bit),
        .is_parity_bit(is_parity_bit),
        .is_stop_bit  (is_stop_bit),
        .tx_done      (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running baud strobe: one clk wide, every 16 clocks, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 15) ? 0 : div + 1;
            baud_tick = (div == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, frames_done=%0d required=%0d",
                 frames_done, exp_done);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic frame_t make_frame(input logic [8:0] data, input int nbits,
                                          input bit has_par, input logic par, input bit two_stop);
        frame_t f;
        int     k;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        k = 1;
        for (int i = 0; i < nbits; i++) begin
            f.bits[k] = data[i];
            k++;
        end
        if (has_par) begin
            f.bits[k] = par;
            k++;
        end
        k = two_stop ? k + 2 : k + 1;
        f.len     = k;
        f.nbits   = nbits;
        f.has_par = has_par;
        return f;
    endfunction

    function automatic logic [4:0] kind_of(input frame_t f, input int k);
        if (k == 0) return 5'b11000;
        if (k <= f.nbits) return 5'b10100;
        if (f.has_par && k == f.nbits + 1) return 5'b10010;
        return 5'b10001;
    endfunction

    // Line monitor: a falling tx after a tick edge starts the next expected frame.
    initial begin
        frame_t cur;
        logic   was_tick;
        logic   prev_tx;
        bit     in_frame;
        int     k;
        int     cyc;
        int     start_cyc;
        in_frame = 0;
        prev_tx  = 1'b1;
        cyc      = 0;
        k        = 0;
        start_cyc = 0;
        forever begin
            @(posedge clk);
            was_tick = baud_tick;
            #1;
            cyc++;
            if (rst) begin
                in_frame = 0;
                prev_tx  = 1'b1;
                continue;
            end
            if (!was_tick) checkOutput("tx_stable_between_ticks", tx, prev_tx);
            if (was_tick) begin
                if (!in_frame) begin
                    if (tx === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_start_bit");
                        end else begin
                            cur = exp_q.pop_front();
                            in_frame  = 1;
                            k         = 0;
                            start_cyc = cyc;
                            checkOutput("start_indicators",
                                        {frame_active, is_start_bit, is_data_bit, is_parity_bit, is_stop_bit},
                                        kind_of(cur, 0));
                        end
                    end
                end else begin
                    k++;
                    if (k < cur.len) begin
                        checkOutput("frame_bit", tx, cur.bits[k]);
                        checkOutput("bit_indicators",
                                    {frame_active, is_start_bit, is_data_bit, is_parity_bit, is_stop_bit},
                                    kind_of(cur, k));
                        if (k <= cur.nbits) checkOutput("bit_count_in_data", bit_count, k - 1);
                        if (k == cur.nbits + 1) checkOutput("bit_count_final", bit_count, cur.nbits);
                    end else begin
                        checkOutput("end_tx_high", tx, 1);
                        checkOutput("end_tx_done", tx_done, 1);
                        checkOutput("end_tx_ready", tx_ready, 1);
                        checkOutput("end_indicators",
                                    {frame_active, is_start_bit, is_data_bit, is_parity_bit, is_stop_bit}, 0);
                        checkOutput("frame_length_clk", cyc - start_cyc, cur.len * 16);
                        in_frame = 0;
                        frames_done++;
                    end
                end
            end
            if (tx_done === 1'b1) done_pulses++;
            prev_tx = tx;
        end
    end

    task automatic wait_ready();
        int c;
        c = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (tx_ready !== 1'b1) fail_now("ready_timeout");
    endtask

    task automatic applyStimulus(input vec_t v);
        wait_ready();
        tx_data     = v.data;
        data_bits   = v.dbits;
        parity_mode = v.pmode;
        stop_bits   = v.sbits;
        tx_valid    = 1'b1;
        exp_q.push_back(make_frame(v.data, v.exp_nbits, v.pmode != 2'd0, v.exp_par, v.sbits));
        exp_done++;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("accept_busy", tx_ready, 0);
        tx_data     = 9'($urandom);
        data_bits   = 4'($urandom_range(0, 15));
        parity_mode = 2'($urandom);
        stop_bits   = 1'($urandom);
    endtask

    task automatic wait_frames(input int target);
        for (int c = 0; c < 1000 && frames_done < target; c++) @(negedge clk);
        if (frames_done < target) fail_now("frame_timeout");
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < n * 20 && seen < n; c++) begin
            @(posedge clk);
            if (baud_tick) seen++;
        end
        if (seen < n) fail_now("tick_timeout");
    endtask

    initial begin
        vec_t v;
        bit   got;
        vecs[0] = '{data: 9'h055, dbits: 4'd8,  pmode: 2'd0, sbits: 1'b0, exp_nbits: 8, exp_par: 1'b0};
        vecs[1] = '{data: 9'h0A3, dbits: 4'd8,  pmode: 2'd1, sbits: 1'b0, exp_nbits: 8, exp_par: 1'b1};
        vecs[2] = '{data: 9'h041, dbits: 4'd7,  pmode: 2'd2, sbits: 1'b1, exp_nbits: 7, exp_par: 1'b0};
        vecs[3] = '{data: 9'h1FE, dbits: 4'd9,  pmode: 2'd3, sbits: 1'b0, exp_nbits: 9, exp_par: 1'b1};
        vecs[4] = '{data: 9'h0EB, dbits: 4'd3,  pmode: 2'd2, sbits: 1'b0, exp_nbits: 5, exp_par: 1'b1};
        vecs[5] = '{data: 9'h1AB, dbits: 4'd12, pmode: 2'd1, sbits: 1'b0, exp_nbits: 9, exp_par: 1'b1};
        vecs[6] = '{data: 9'h015, dbits: 4'd5,  pmode: 2'd0, sbits: 1'b1, exp_nbits: 5, exp_par: 1'b0};
        vecs[7] = '{data: 9'h02D, dbits: 4'd6,  pmode: 2'd2, sbits: 1'b0, exp_nbits: 6, exp_par: 1'b0};

        rst         = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 9'h000;
        data_bits   = 4'd8;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_ready", tx_ready, 1);
        checkOutput("reset_done", tx_done, 0);
        checkOutput("reset_bit_count", bit_count, 0);
        checkOutput("reset_indicators",
                    {frame_active, is_start_bit, is_data_bit, is_parity_bit, is_stop_bit}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checkOutput("idle_tx_high", tx, 1);
            checkOutput("idle_ready", tx_ready, 1);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            wait_frames(exp_done);
        end

        // Back-to-back: tx_valid held, data changed mid-frame to the second word.
        wait_ready();
        tx_data     = 9'h012;
        data_bits   = 4'd8;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        tx_valid    = 1'b1;
        exp_q.push_back(make_frame(9'h012, 8, 0, 1'b0, 0));
        exp_done++;
        @(negedge clk);
        checkOutput("b2b_busy", tx_ready, 0);
        tx_data = 9'h034;
        exp_q.push_back(make_frame(9'h034, 8, 0, 1'b0, 0));
        exp_done++;
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (tx_ready) begin
                checkOutput("b2b_ready_only_with_done", tx_done, 1);
                got = 1;
            end
        end
        if (!got) fail_now("b2b_ready_timeout");
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("b2b_second_accepted", tx_ready, 0);
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            if (baud_tick) got = 1;
        end
        #1;
        if (!got) fail_now("b2b_tick_timeout");
        else checkOutput("b2b_start_at_first_tick", tx, 0);
        wait_frames(exp_done);

        // Asynchronous reset in the middle of a data bit.
        v = '{data: 9'h000, dbits: 4'd8, pmode: 2'd0, sbits: 1'b0, exp_nbits: 8, exp_par: 1'b0};
        applyStimulus(v);
        exp_done--;
        wait_ticks(3);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pre_reset_tx_low", tx, 0);
        checkOutput("pre_reset_data_bit", is_data_bit, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_tx", tx, 1);
        checkOutput("async_reset_ready", tx_ready, 1);
        checkOutput("async_reset_bit_count", bit_count, 0);
        checkOutput("async_reset_active", frame_active, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_queue_drained", exp_q.size(), 0);

        v = '{data: 9'h03C, dbits: 4'd8, pmode: 2'd2, sbits: 1'b0, exp_nbits: 8, exp_par: 1'b0};
        applyStimulus(v);
        wait_frames(exp_done);

        repeat (20) @(negedge clk);
        checkOutput("frames_seen", frames_done, exp_done);
        checkOutput("done_pulses", done_pulses, exp_done);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
